// File: rtl/uart_io_master.sv
// UART-driven I/O bus initiator: decodes 'W' (57) / 'R' (52) frames from a byte receiver and replays them on the j1b I/O bus.
// Optional inter-byte frame timeout is enabled by defining UART_IO_MASTER_TIMEOUT_EN.
module uart_io_master #(
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_rd,
    input  logic        tx_busy,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        io_req,
    input  logic        io_gnt,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] io_addr,
    output logic [31:0] io_dout,
    input  logic [31:0] io_din,
    output logic        active,
    output logic        frame_abort
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        STB,
        SAMPLE,
        ACK,
        TX
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;

    state_t      state_q, state_d;
    logic        wr_flag_q, wr_flag_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] dout_q, dout_d;
    logic        rx_rd_q, rx_rd_d;
    logic        rx_hold_q, rx_hold_d;
    logic        tx_wr_q, tx_wr_d;
    logic        tx_hold_q, tx_hold_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [31:0] tx_buf_q, tx_buf_d;
    logic [2:0]  tx_cnt_q, tx_cnt_d;
    logic        io_req_q, io_req_d;
    logic        io_rd_q, io_rd_d;
    logic        io_wr_q, io_wr_d;
    logic        active_q, active_d;
    logic        frame_abort_q, frame_abort_d;

    logic        byte_state;
    logic        rx_take;
    logic        tx_state;
    logic        tx_go;
    logic [31:0] tx_src;
    logic [2:0]  tx_left;

`ifdef UART_IO_MASTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // rx_rd is registered, so both the rx_rd cycle and the one after it must ignore a stale rx_valid.
    assign byte_state = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
    assign rx_take    = byte_state && rx_valid && !rx_rd_q && !rx_hold_q;

    // SAMPLE and ACK feed the transmit path directly so the first byte can leave without an extra cycle.
    assign tx_state = (state_q == SAMPLE) || (state_q == ACK) || (state_q == TX);
    assign tx_go    = tx_state && !tx_busy && !tx_wr_q && !tx_hold_q;
    assign tx_src   = (state_q == SAMPLE) ? io_din :
                      (state_q == ACK)    ? {ACK_BYTE, 24'h000000} : tx_buf_q;
    assign tx_left  = (state_q == SAMPLE) ? 3'd4 :
                      (state_q == ACK)    ? 3'd1 : tx_cnt_q;

    always_comb begin
        state_d       = state_q;
        wr_flag_d     = wr_flag_q;
        byte_cnt_d    = byte_cnt_q;
        addr_d        = addr_q;
        dout_d        = dout_q;
        rx_rd_d       = rx_take;
        rx_hold_d     = rx_rd_q;
        tx_wr_d       = 1'b0;
        tx_hold_d     = tx_wr_q;
        tx_data_d     = tx_data_q;
        tx_buf_d      = tx_buf_q;
        tx_cnt_d      = tx_cnt_q;
        io_rd_d       = 1'b0;
        io_wr_d       = 1'b0;
        frame_abort_d = 1'b0;
`ifdef UART_IO_MASTER_TIMEOUT_EN
        to_cnt_d      = '0;
`endif

        case (state_q)
            IDLE: begin
                if (rx_take) begin
                    byte_cnt_d = 2'd0;
                    if (rx_data == CMD_WR) begin
                        wr_flag_d = 1'b1;
                        state_d   = ADDR;
                    end else if (rx_data == CMD_RD) begin
                        wr_flag_d = 1'b0;
                        state_d   = ADDR;
                    end
                end
            end
            ADDR: begin
                if (rx_take) begin
                    addr_d = {addr_q[7:0], rx_data};
                    if (byte_cnt_q == 2'd1) begin
                        byte_cnt_d = 2'd0;
                        state_d    = wr_flag_q ? DATA : REQ;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            DATA: begin
                if (rx_take) begin
                    dout_d = {dout_q[23:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        state_d    = REQ;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            REQ: begin
                if (io_gnt) begin
                    state_d = STB;
                    io_wr_d = wr_flag_q;
                    io_rd_d = !wr_flag_q;
                end
            end
            STB: begin
                state_d = wr_flag_q ? ACK : SAMPLE;
            end
            SAMPLE, ACK, TX: begin
                state_d  = TX;
                tx_buf_d = tx_src;
                tx_cnt_d = tx_left;
                if (tx_go) begin
                    tx_wr_d   = 1'b1;
                    tx_data_d = tx_src[31:24];
                    tx_buf_d  = {tx_src[23:0], 8'h00};
                    tx_cnt_d  = tx_left - 3'd1;
                    if (tx_left == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef UART_IO_MASTER_TIMEOUT_EN
        // Idle time is measured only while a frame is being collected; any accepted byte restarts it.
        if ((state_q == ADDR || state_q == DATA) && !rx_take) begin
            if (to_cnt_q == TO_LAST) begin
                state_d       = IDLE;
                wr_flag_d     = 1'b0;
                byte_cnt_d    = 2'd0;
                addr_d        = '0;
                dout_d        = '0;
                frame_abort_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif

        io_req_d = (state_d == REQ) || (state_d == STB) || (state_d == SAMPLE);
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q       <= IDLE;
            wr_flag_q     <= 1'b0;
            byte_cnt_q    <= 2'd0;
            addr_q        <= '0;
            dout_q        <= '0;
            rx_rd_q       <= 1'b0;
            rx_hold_q     <= 1'b0;
            tx_wr_q       <= 1'b0;
            tx_hold_q     <= 1'b0;
            tx_data_q     <= '0;
            tx_buf_q      <= '0;
            tx_cnt_q      <= 3'd0;
            io_req_q      <= 1'b0;
            io_rd_q       <= 1'b0;
            io_wr_q       <= 1'b0;
            active_q      <= 1'b0;
            frame_abort_q <= 1'b0;
`ifdef UART_IO_MASTER_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_flag_q     <= wr_flag_d;
            byte_cnt_q    <= byte_cnt_d;
            addr_q        <= addr_d;
            dout_q        <= dout_d;
            rx_rd_q       <= rx_rd_d;
            rx_hold_q     <= rx_hold_d;
            tx_wr_q       <= tx_wr_d;
            tx_hold_q     <= tx_hold_d;
            tx_data_q     <= tx_data_d;
            tx_buf_q      <= tx_buf_d;
            tx_cnt_q      <= tx_cnt_d;
            io_req_q      <= io_req_d;
            io_rd_q       <= io_rd_d;
            io_wr_q       <= io_wr_d;
            active_q      <= active_d;
            frame_abort_q <= frame_abort_d;
`ifdef UART_IO_MASTER_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign rx_rd       = rx_rd_q;
    assign tx_wr       = tx_wr_q;
    assign tx_data     = tx_data_q;
    assign io_req      = io_req_q;
    assign io_rd       = io_rd_q;
    assign io_wr       = io_wr_q;
    assign io_addr     = addr_q;
    assign io_dout     = dout_q;
    assign active      = active_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: doc/uart_io_master.md
Name: uart_io_master

Overview:
- Host-driven initiator on the j1b I/O bus, placed beside the CPU.
- Consumes a byte stream from a buart receiver and decodes framed read/write commands.
- Issues single io_rd/io_wr transactions to the same peripheral address map the CPU uses, then returns results through a buart transmitter.
- An external mux grants the bus to this block through io_req/io_gnt, giving debug/boot access without CPU involvement.

Parameters:
- ACK_BYTE, 8'h06, byte transmitted after each completed write.
- TIMEOUT_CYCLES, 2500000, maximum idle cycles between bytes of one frame (100 ms at 25 MHz); used only with the optional feature.

Ports:
- clk  input  1  system clock
- resetq  input  1  asynchronous active-low reset
- rx_valid  input  1  receiver holds an unread byte
- rx_data  input  8  received byte
- rx_rd  output  1  one-cycle pulse, consumes rx_data
- tx_busy  input  1  transmitter busy
- tx_wr  output  1  one-cycle pulse, loads tx_data
- tx_data  output  8  byte to transmit
- io_req  output  1  bus request, held until transaction complete
- io_gnt  input  1  bus grant from external mux
- io_rd  output  1  one-cycle read strobe
- io_wr  output  1  one-cycle write strobe
- io_addr  output  16  bus address
- io_dout  output  32  write data
- io_din  input  32  read data; registered by the responder, valid one cycle after io_addr is presented
- active  output  1  frame in progress (state != IDLE)
- frame_abort  output  1  one-cycle pulse when a partial frame is discarded

Behaviour:
- Reset (resetq low, async):
  - State = IDLE.
  - All outputs 0: rx_rd, tx_wr, tx_data, io_req, io_rd, io_wr, io_addr, io_dout, active, frame_abort.
  - Byte counter, shift registers and timeout counter cleared.
  - Reset mid-frame or mid-transaction discards everything; no strobe or tx byte is emitted afterwards.
- Frame formats (multi-byte fields are big-endian):
  - Write: 8'h57, A1, A0, D3, D2, D1, D0.
  - Read: 8'h52, A1, A0.
- Byte intake:
  - In byte-accepting states, rx_valid=1 -> rx_rd pulses high for one cycle and rx_data is captured that cycle.
  - rx_valid is ignored in the cycle after rx_rd, covering the receiver's valid-clear latency.
- States and transitions:
  - IDLE: accepts a byte.
    - 57 -> ADDR with wr flag set.
    - 52 -> ADDR with wr flag cleared.
    - Any other byte is consumed and dropped; state stays IDLE.
  - ADDR: captures 2 bytes into io_addr (A1 into [15:8]). Then:
    - wr flag set -> DATA.
    - wr flag clear -> REQ.
  - DATA: captures 4 bytes into io_dout, then -> REQ.
  - REQ: io_req=1, held until leaving SAMPLE/WSTB. When io_gnt=1 in REQ -> STB next cycle. io_addr and io_dout are stable from REQ entry.
  - STB: exactly one cycle.
    - Write: io_wr=1 -> ACK.
    - Read: io_rd=1 -> SAMPLE.
  - SAMPLE: latches io_din into a 32-bit result; io_req drops; -> TX with 4 bytes queued.
  - ACK: queues ACK_BYTE (1 byte); io_req drops; -> TX.
  - TX:
    - When tx_busy=0, pulse tx_wr with the next byte (result[31:24] first).
    - tx_busy is ignored in the cycle after tx_wr.
    - After the last byte -> IDLE.
- Grant loss: if io_gnt drops in REQ, the block waits there indefinitely. The grant is sampled only in REQ.
- Flow control: bytes arriving during REQ/STB/SAMPLE/ACK/TX stay in the receiver and are not consumed until IDLE.
- Latency: a read completes 3 cycles after grant (STB, SAMPLE, first TX check). The earliest tx_wr is 2 cycles after the io_rd cycle.
- active is high in every state except IDLE.

Optional Feature:
- Macro: UART_IO_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in ADDR/DATA and resets on every accepted byte.
  - On reaching TIMEOUT_CYCLES: state -> IDLE, partial fields discarded, frame_abort pulses 1 cycle, no bus activity.
  - The counter does not run in REQ..TX.
- Undefined:
  - No counter logic; frame_abort tied 0.
  - A partial frame waits forever.

Test Plan:
- Write: feed 57 04 04 00 00 00 A5, grant immediately -> exactly one io_wr cycle with io_addr=16'h0404 and io_dout=32'h000000A5, then tx byte 8'h06; active returns 0.
- Read: feed 52 10 10; bench drives io_din=32'h017D7840 one cycle after io_rd -> tx bytes 01 7D 78 40 in order, each tx_wr only when tx_busy=0.
- Junk and grant delay:
  - Feed 00 FF before a read -> both bytes consumed, no bus activity.
  - Hold io_gnt=0 for 50 cycles -> io_req held, no strobe; strobe occurs 1 cycle after io_gnt rises.
- Reset mid-DATA: deassert resetq after 3 data bytes -> outputs all 0 immediately. A fresh read frame then completes correctly.
- With UART_IO_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=100:
  - Feed 57 12 then stall 100 cycles -> frame_abort pulse, IDLE, no io_wr.
  - A subsequent 52 20 00 read -> 4 tx bytes.
